retire_trace_unit: RTL and testbench
====================================

RETIRE_TRACE_UNIT -- requirements
Module: retire_trace_unit

Interface
REQ-001 SHALL have parameter PC_W, default 9: program-counter width.
REQ-002 SHALL have parameter DATA_W, default 32: jump-output data width.
REQ-003 SHALL have parameter DEPTH, default 16: trace entries; power of 2, >= 2.
REQ-004 SHALL have parameter CNT_W, default 32: event-counter width.
REQ-005 SHALL have port clk, input, 1: the single clock; all state on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port inst_done, input, 1: one-cycle pulse per retired instruction.
REQ-008 SHALL have port nop, input, 1: retired instruction was a nop; valid with inst_done.
REQ-009 SHALL have port pc, input, PC_W: PC of the retired instruction; valid with inst_done.
REQ-010 SHALL have port jout, input, DATA_W: core jump output; valid with inst_done.
REQ-011 SHALL have port trc_valid, output, 1: trace head available.
REQ-012 SHALL have port trc_ready, input, 1: consumer accepts head.
REQ-013 SHALL have ports trc_pc (PC_W), trc_nop (1) and trc_jout (DATA_W), outputs: head entry fields.
REQ-014 SHALL have port trc_count, output, log2(DEPTH)+1: entries held.
REQ-015 SHALL have port overflow, output, 1: sticky dropped-entry flag; clr_overflow, input, 1, clears it.
REQ-016 SHALL have ports retired and nop_count, outputs, CNT_W: retire and nop counters.
REQ-017 SHALL have ports brk_en (input, 1), brk_pc (input, PC_W) and resume (input, 1): breakpoint control.
REQ-018 SHALL have port halt, output, 1: core-stall request.

Function
REQ-019 SHALL push {pc, nop, jout} on each cycle with inst_done=1 when not full, or when full with a pop in the same cycle.
REQ-020 SHALL pop when trc_valid and trc_ready are both 1; push and pop in one cycle leave trc_count unchanged.
REQ-021 SHALL be first-word-fall-through: a push into an empty buffer gives trc_valid=1 on the next cycle with head fields equal to the pushed values.
REQ-022 SHALL hold trc_valid=0 when empty; head fields are don't-care; a pop while empty is ignored.
REQ-023 SHALL drop the entry on inst_done when full without a pop, and set overflow on the next cycle.
REQ-024 SHALL let a set of overflow win over clr_overflow in the same cycle.
REQ-025 SHALL wrap read and write pointers modulo DEPTH; trc_count never exceeds DEPTH.
REQ-026 SHALL increment retired on each inst_done, and nop_count on inst_done with nop=1; both wrap modulo 2^CNT_W.
REQ-027 SHALL count, capture and breakpoint-check every inst_done regardless of halt.
REQ-028 SHALL implement a 2-state machine, RUN and HALT, with halt=1 exactly in HALT.
REQ-029 SHALL move RUN->HALT when brk_en=1, inst_done=1 and pc==brk_pc, with halt=1 from the next cycle.
REQ-030 SHALL move HALT->RUN when resume=1 and no breakpoint hit occurs in the same cycle; a simultaneous hit keeps HALT.
REQ-031 SHALL ignore resume while in RUN.

Reset
REQ-032 SHALL, while rst=0, immediately force: buffer empty, trc_valid=0, trc_count=0, overflow=0, retired=0, nop_count=0, state RUN, halt=0.
REQ-033 SHALL discard buffered entries on reset assertion mid-operation, and perform the first capture no earlier than the first rising edge after rst returns to 1.

Structure
REQ-034 SHALL place default parameter values, the trace-entry struct {pc, nop, jout} and the RUN/HALT state enum in shared package core_dbg_pkg.
REQ-035 SHALL implement the buffer as sub-module trace_fifo, a parametrised first-word-fall-through synchronous FIFO with a count output.

Verification
REQ-036 SHALL cover single capture: inst_done with pc=0x005, nop=0, jout=0x1234 -> next cycle trc_valid=1, trc_pc=0x005, trc_jout=0x1234, trc_count=1, retired=1.
REQ-037 SHALL cover fill/overflow: 17 inst_done pulses, trc_ready=0, DEPTH=16 -> trc_count=16, overflow=1, head is pulse 1, retired=17.
REQ-038 SHALL cover full with simultaneous push and pop: trc_count=16, inst_done plus pop -> trc_count stays 16, overflow stays 0, new head is the old second entry.
REQ-039 SHALL cover breakpoint: brk_en=1, brk_pc=0x010, retire at pc 0x00F then 0x010 -> halt=1 the cycle after the 0x010 retire; resume -> halt=0 next cycle; resume coincident with a new hit -> halt stays 1.
REQ-040 SHALL cover counter wrap with CNT_W=4: 16 pulses with nop=1 -> retired=0, nop_count=0.
REQ-041 SHALL cover reset mid-stream: rst=0 with 5 entries buffered and halt=1 -> all outputs at reset values without waiting for a clock edge.

Source files
------------

// File: rtl/core_dbg_pkg.sv
// -----------------------------------------------------------------------------
// core_dbg_pkg
// Shared definitions for the retire trace / breakpoint debug block.
//   - Default parameter values for the trace unit.
//   - trace_entry_t : one captured retirement {pc, nop, jout} at default widths.
//   - dbg_state_e   : run/halt state of the breakpoint machine.
//   - entry_width() : packed width of a trace entry for arbitrary field widths.
// -----------------------------------------------------------------------------
package core_dbg_pkg;

    localparam int DEF_PC_W   = 9;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_CNT_W  = 32;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } dbg_state_e;

    // Field order is the canonical entry layout: pc in the top bits, jout lowest.
    typedef struct packed {
        logic [DEF_PC_W-1:0]   pc;
        logic                  nop;
        logic [DEF_DATA_W-1:0] jout;
    } trace_entry_t;

    function automatic int entry_width(input int pc_w, input int data_w);
        return pc_w + 1 + data_w;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// -----------------------------------------------------------------------------
// trace_fifo
// Parametrised first-word-fall-through synchronous FIFO with occupancy count.
//   clk, rst (async, active-low)
//   push, push_data : write request; accepted when not full, or when full and a
//                     pop is accepted in the same cycle
//   pop             : read request; ignored while empty
//   rd_data         : head entry (valid whenever empty is 0)
//   count           : entries held, 0..DEPTH
//   full, empty     : occupancy flags
// -----------------------------------------------------------------------------
module trace_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // A full FIFO still takes a write when the head leaves in the same cycle,
    // because the freed slot and the written slot are consumed together.
    always_comb begin
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is read out of a slot before it is written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/retire_trace_unit.sv
// -----------------------------------------------------------------------------
// retire_trace_unit
// Captures every retired instruction into a FWFT trace buffer, counts retires
// and nops, and raises a halt request when a retire hits the breakpoint PC.
//   clk, rst (async, active-low)
//   inst_done, nop, pc, jout        : retirement pulse and its payload
//   trc_valid, trc_ready            : trace head handshake
//   trc_pc, trc_nop, trc_jout       : head entry fields
//   trc_count                       : entries buffered
//   overflow, clr_overflow          : sticky dropped-entry flag and its clear
//   retired, nop_count              : wrapping event counters
//   brk_en, brk_pc, resume, halt    : breakpoint control and core stall request
// -----------------------------------------------------------------------------
module retire_trace_unit
    import core_dbg_pkg::*;
#(
    parameter  int PC_W   = DEF_PC_W,
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int DEPTH  = DEF_DEPTH,
    parameter  int CNT_W  = DEF_CNT_W,
    localparam int AW     = $clog2(DEPTH),
    localparam int EW     = entry_width(PC_W, DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_done,
    input  logic              nop,
    input  logic [PC_W-1:0]   pc,
    input  logic [DATA_W-1:0] jout,
    output logic              trc_valid,
    input  logic              trc_ready,
    output logic [PC_W-1:0]   trc_pc,
    output logic              trc_nop,
    output logic [DATA_W-1:0] trc_jout,
    output logic [AW:0]       trc_count,
    output logic              overflow,
    input  logic              clr_overflow,
    output logic [CNT_W-1:0]  retired,
    output logic [CNT_W-1:0]  nop_count,
    input  logic              brk_en,
    input  logic [PC_W-1:0]   brk_pc,
    input  logic              resume,
    output logic              halt
);

    // Same layout as trace_entry_t, sized for this instance's widths.
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic              nop;
        logic [DATA_W-1:0] jout;
    } entry_t;

    entry_t            push_entry;
    entry_t            head_entry;
    logic [EW-1:0]     fifo_rd_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              drop;
    logic              hit;

    logic              overflow_q,  overflow_d;
    logic [CNT_W-1:0]  retired_q,   retired_d;
    logic [CNT_W-1:0]  nop_count_q, nop_count_d;
    dbg_state_e        state_q,     state_d;
    logic              halt_q,      halt_d;

    assign push_entry = '{pc: pc, nop: nop, jout: jout};

    trace_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inst_done),
        .push_data (push_entry),
        .pop       (pop),
        .rd_data   (fifo_rd_data),
        .count     (trc_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_entry = entry_t'(fifo_rd_data);
    assign trc_valid  = !fifo_empty;
    assign trc_pc     = head_entry.pc;
    assign trc_nop    = head_entry.nop;
    assign trc_jout   = head_entry.jout;
    assign overflow   = overflow_q;
    assign retired    = retired_q;
    assign nop_count  = nop_count_q;
    assign halt       = halt_q;

    // Retirement bookkeeping and breakpoint machine. Capture, counting and
    // breakpoint matching all run while halted so no retire is ever missed.
    always_comb begin
        pop  = trc_valid && trc_ready;
        drop = inst_done && fifo_full && !pop;
        hit  = brk_en && inst_done && (pc == brk_pc);

        // A drop in the same cycle as a clear must leave the flag set.
        overflow_d  = drop || (overflow_q && !clr_overflow);
        retired_d   = retired_q + CNT_W'(inst_done);
        nop_count_d = nop_count_q + CNT_W'(inst_done && nop);

        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (hit) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (resume && !hit) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
        halt_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q  <= 1'b0;
            retired_q   <= '0;
            nop_count_q <= '0;
            state_q     <= ST_RUN;
            halt_q      <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            retired_q   <= retired_d;
            nop_count_q <= nop_count_d;
            state_q     <= state_d;
            halt_q      <= halt_d;
        end
    end

endmodule

// File: tb/tb_retire_trace_unit.sv
// -----------------------------------------------------------------------------
// tb_retire_trace_unit
// Drives two retire_trace_unit instances from the same inputs (default counter
// width and a 4-bit counter width) and compares them every cycle against a
// queue-based model of the trace buffer, counters and halt behaviour.
// -----------------------------------------------------------------------------
module tb_retire_trace_unit;

    localparam int PC_W   = 9;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst;
    logic              inst_done;
    logic              nop;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] jout;
    logic              trc_ready;
    logic              clr_overflow;
    logic              brk_en;
    logic [PC_W-1:0]   brk_pc;
    logic              resume;

    logic              trc_valid,  w_trc_valid;
    logic [PC_W-1:0]   trc_pc,     w_trc_pc;
    logic              trc_nop,    w_trc_nop;
    logic [DATA_W-1:0] trc_jout,   w_trc_jout;
    logic [CW-1:0]     trc_count,  w_trc_count;
    logic              overflow,   w_overflow;
    logic [31:0]       retired,    nop_count;
    logic [3:0]        w_retired,  w_nop_count;
    logic              halt,       w_halt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [PC_W-1:0]   pc;
        logic              nop;
        logic [DATA_W-1:0] jout;
    } ent_t;

    ent_t        m_q[$];
    logic        m_overflow;
    int unsigned m_retired;
    int unsigned m_nop;
    logic        m_halt;

    retire_trace_unit dut (
        .clk(clk), .rst(rst), .inst_done(inst_done), .nop(nop), .pc(pc), .jout(jout),
        .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_pc(trc_pc), .trc_nop(trc_nop),
        .trc_jout(trc_jout), .trc_count(trc_count), .overflow(overflow),
        .clr_overflow(clr_overflow), .retired(retired), .nop_count(nop_count),
        .brk_en(brk_en), .brk_pc(brk_pc), .resume(resume), .halt(halt)
    );

    retire_trace_unit #(.CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .inst_done(inst_done), .nop(nop), .pc(pc), .jout(jout),
        .trc_valid(w_trc_valid), .trc_ready(trc_ready), .trc_pc(w_trc_pc), .trc_nop(w_trc_nop),
        .trc_jout(w_trc_jout), .trc_count(w_trc_count), .overflow(w_overflow),
        .clr_overflow(clr_overflow), .retired(w_retired), .nop_count(w_nop_count),
        .brk_en(brk_en), .brk_pc(brk_pc), .resume(resume), .halt(w_halt)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point; every check in the bench goes through here.
    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_overflow = 1'b0;
        m_retired  = 0;
        m_nop      = 0;
        m_halt     = 1'b0;
    endfunction

    // Advance the model by one clock edge from the inputs currently driven.
    function automatic void model_step();
        bit   pop_now;
        bit   full_now;
        bit   hit;
        bit   dropped;
        ent_t e;
        pop_now  = (m_q.size() != 0) && trc_ready;
        full_now = (m_q.size() == DEPTH);
        hit      = brk_en && inst_done && (pc == brk_pc);
        dropped  = 1'b0;
        if (pop_now) void'(m_q.pop_front());
        if (inst_done) begin
            if (!full_now || pop_now) begin
                e.pc = pc; e.nop = nop; e.jout = jout;
                m_q.push_back(e);
            end else begin
                dropped = 1'b1;
            end
            m_retired++;
            if (nop) m_nop++;
        end
        if (dropped)           m_overflow = 1'b1;
        else if (clr_overflow) m_overflow = 1'b0;
        if (m_halt) m_halt = !(resume && !hit);
        else        m_halt = hit;
    endfunction

    task automatic checkOutput();
        check_val("trc_valid",  64'(trc_valid),   64'(m_q.size() != 0));
        check_val("trc_count",  64'(trc_count),   64'(m_q.size()));
        check_val("overflow",   64'(overflow),    64'(m_overflow));
        check_val("retired",    64'(retired),     64'(m_retired));
        check_val("nop_count",  64'(nop_count),   64'(m_nop));
        check_val("halt",       64'(halt),        64'(m_halt));
        check_val("w_retired",  64'(w_retired),   64'(m_retired % 16));
        check_val("w_nop",      64'(w_nop_count), 64'(m_nop % 16));
        check_val("w_count",    64'(w_trc_count), 64'(m_q.size()));
        check_val("w_halt",     64'(w_halt),      64'(m_halt));
        if (m_q.size() != 0) begin
            check_val("trc_pc",   64'(trc_pc),   64'(m_q[0].pc));
            check_val("trc_nop",  64'(trc_nop),  64'(m_q[0].nop));
            check_val("trc_jout", 64'(trc_jout), 64'(m_q[0].jout));
            check_val("w_pc",     64'(w_trc_pc), 64'(m_q[0].pc));
        end
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic applyStimulus(input logic d, input logic n, input logic [PC_W-1:0] p,
                                 input logic [DATA_W-1:0] j, input logic rdy,
                                 input logic clr, input logic res);
        inst_done    = d;
        nop          = n;
        pc           = p;
        jout         = j;
        trc_ready    = rdy;
        clr_overflow = clr;
        resume       = res;
        model_step();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic set_idle();
        inst_done = 0; nop = 0; pc = '0; jout = '0;
        trc_ready = 0; clr_overflow = 0; resume = 0;
    endtask

    task automatic reset_literals(input string tag);
        check_val({tag, "_valid"},   64'(trc_valid), 64'd0);
        check_val({tag, "_count"},   64'(trc_count), 64'd0);
        check_val({tag, "_ovf"},     64'(overflow),  64'd0);
        check_val({tag, "_retired"}, 64'(retired),   64'd0);
        check_val({tag, "_nop"},     64'(nop_count), 64'd0);
        check_val({tag, "_halt"},    64'(halt),      64'd0);
    endtask

    // Assert reset away from any clock edge and check outputs before the next edge.
    task automatic do_reset();
        set_idle();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        reset_literals("rst");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        set_idle();
        brk_en = 1'b0;
        brk_pc = '0;
        rst    = 1'b0;
        model_reset();
        #2;
        reset_literals("por");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput();

        // Single capture.
        applyStimulus(1, 0, 9'h005, 32'h1234, 0, 0, 0);
        check_val("cap_valid",   64'(trc_valid), 64'd1);
        check_val("cap_pc",      64'(trc_pc),    64'h005);
        check_val("cap_jout",    64'(trc_jout),  64'h1234);
        check_val("cap_count",   64'(trc_count), 64'd1);
        check_val("cap_retired", 64'(retired),   64'd1);
        applyStimulus(0, 0, '0, '0, 1, 0, 0);
        applyStimulus(0, 0, '0, '0, 1, 0, 0);

        // Fill to DEPTH, then one more retire is dropped.
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            applyStimulus(1, 1'(i), PC_W'(9'h020 + i), DATA_W'(32'hA000 + i), 0, 0, 0);
        end
        check_val("fill_count",   64'(trc_count), 64'd16);
        check_val("fill_ovf",     64'(overflow),  64'd1);
        check_val("fill_head",    64'(trc_pc),    64'h021);
        check_val("fill_retired", 64'(retired),   64'd17);
        check_val("fill_wret",    64'(w_retired), 64'd1);

        // A drop coinciding with a clear keeps the flag set; a plain clear drops it.
        applyStimulus(1, 0, 9'h050, 32'h50, 0, 1, 0);
        check_val("ovf_set_wins", 64'(overflow), 64'd1);
        applyStimulus(0, 0, '0, '0, 0, 1, 0);
        check_val("ovf_clr", 64'(overflow), 64'd0);

        // Full with push and pop together.
        applyStimulus(1, 0, 9'h040, 32'h40, 1, 0, 0);
        check_val("fp_count", 64'(trc_count), 64'd16);
        check_val("fp_ovf",   64'(overflow),  64'd0);
        check_val("fp_head",  64'(trc_pc),    64'h022);

        // Breakpoint, resume, and resume coincident with a new hit.
        do_reset();
        brk_en = 1'b1;
        brk_pc = 9'h010;
        applyStimulus(1, 0, 9'h00F, 32'h1, 1, 0, 0);
        check_val("bp_miss", 64'(halt), 64'd0);
        applyStimulus(1, 0, 9'h010, 32'h2, 1, 0, 0);
        check_val("bp_hit", 64'(halt), 64'd1);
        applyStimulus(0, 0, '0, '0, 1, 0, 1);
        check_val("bp_resume", 64'(halt), 64'd0);
        applyStimulus(1, 0, 9'h010, 32'h3, 1, 0, 0);
        check_val("bp_hit2", 64'(halt), 64'd1);
        applyStimulus(1, 0, 9'h010, 32'h4, 1, 0, 1);
        check_val("bp_res_hit", 64'(halt), 64'd1);
        applyStimulus(0, 0, '0, '0, 1, 0, 1);
        check_val("bp_resume2", 64'(halt), 64'd0);
        applyStimulus(0, 0, '0, '0, 1, 0, 1);
        check_val("bp_run_res", 64'(halt), 64'd0);

        // Counter wrap on the 4-bit instance.
        do_reset();
        brk_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 1, 9'h001, DATA_W'(i), 1, 0, 0);
        end
        check_val("wrap_ret", 64'(w_retired),   64'd0);
        check_val("wrap_nop", 64'(w_nop_count), 64'd0);
        check_val("wide_ret", 64'(retired),     64'd16);

        // Reset mid-stream with entries buffered and the core halted.
        do_reset();
        brk_en = 1'b1;
        brk_pc = 9'h010;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, PC_W'(9'h030 + i), DATA_W'(i), 0, 0, 0);
        end
        applyStimulus(1, 0, 9'h010, 32'h5, 0, 0, 0);
        check_val("mid_count", 64'(trc_count), 64'd5);
        check_val("mid_halt",  64'(halt),      64'd1);
        do_reset();

        // Randomised traffic around the breakpoint address.
        brk_pc = 9'h010;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end
            if ($urandom_range(0, 63) == 0) brk_en = 1'($urandom_range(0, 3) != 0);
            applyStimulus(1'($urandom_range(0, 9) < 7),
                          1'($urandom_range(0, 1)),
                          PC_W'($urandom_range(9'h00C, 9'h013)),
                          DATA_W'($urandom),
                          1'($urandom_range(0, 9) < 4),
                          1'($urandom_range(0, 19) == 0),
                          1'($urandom_range(0, 9) == 0));
        end

        set_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
